vppm_rx_decoder: RTL and testbench

//  Receive-side VPPM demodulator/deserializer for the optical link. Samples comparator output of the

---
 rtl/vppm_pkg.sv | 27 ++
 rtl/vppm_rx_sync.sv | 24 ++
 rtl/vppm_rx_decoder.sv | 173 +++++++++++++++++
 tb/tb_vppm_rx_decoder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vppm_pkg.sv
// Shared VPPM definitions: receiver state encoding, dimming codes and the
// expected high-sample count per symbol for a dimming level (also used by Tx).
package vppm_pkg;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2
    } vppm_state_e;

    localparam logic [1:0] DIM_50  = 2'b00;
    localparam logic [1:0] DIM_25  = 2'b01;
    localparam logic [1:0] DIM_75  = 2'b10;
    localparam logic [1:0] DIM_125 = 2'b11;

    function automatic int expected_highs(input logic [1:0] dim, input int spb);
        int highs;
        case (dim)
            DIM_25:  highs = spb / 4;
            DIM_75:  highs = (3 * spb) / 4;
            DIM_125: highs = spb / 8;
            default: highs = spb / 2;
        endcase
        return highs;
    endfunction

endpackage

// File: rtl/vppm_rx_sync.sv
// Two-flop synchronizer bringing the raw comparator output into the pclk domain.
module vppm_rx_sync (
    input  logic pclk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic q_reg;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            meta_reg <= 1'b0;
            q_reg    <= 1'b0;
        end else begin
            meta_reg <= d;
            q_reg    <= meta_reg;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/vppm_rx_decoder.sv
// VPPM receive demodulator/deserializer: finds a start symbol after an idle line,
// decodes WORD_W symbols MSB first and strobes each word out. Optional duty-cycle
// checking against the dimming level is enabled by defining VPPM_RX_DUTY_CHECK_EN.
module vppm_rx_decoder
    import vppm_pkg::*;
#(
    parameter int SPB      = 16,
    parameter int WORD_W   = 32,
    parameter int DUTY_TOL = 1
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              rx_in,
    input  logic [1:0]        dim,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_busy,
    output logic              sym_err
);

    localparam int SW = $clog2(SPB);
    localparam int HW = $clog2(SPB / 2) + 1;
    localparam int BW = $clog2(WORD_W + 1);
    localparam int RW = $clog2(SPB + 1);

    logic rs;

    vppm_rx_sync u_sync (
        .pclk (pclk),
        .rst  (rst),
        .d    (rx_in),
        .q    (rs)
    );

    vppm_state_e       state_reg, state_next;
    logic [SW-1:0]     samp_reg, samp_next;
    logic [HW-1:0]     a_reg, a_next;
    logic [HW-1:0]     b_reg, b_next;
    logic [RW-1:0]     low_reg, low_next;
    logic [BW-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [WORD_W-2:0] shreg_reg, shreg_next;
    logic [WORD_W-1:0] rx_data_reg, rx_data_next;
    logic              rx_valid_reg, rx_valid_next;
    logic              sym_err_reg, sym_err_next;

    // Half-period sums including the current sample, so a symbol resolves on its last sample.
    logic          first_half;
    logic          sym_end;
    logic [HW-1:0] a_full;
    logic [HW-1:0] b_full;
    logic          bit_val;
    logic          tie;
    logic          duty_bad;

    assign first_half = (samp_reg < SW'(SPB / 2));
    assign sym_end    = (samp_reg == SW'(SPB - 1));
    assign a_full     = a_reg + HW'(first_half && rs);
    assign b_full     = b_reg + HW'(!first_half && rs);
    assign bit_val    = (b_full > a_full);
    assign tie        = (a_full == b_full);

`ifdef VPPM_RX_DUTY_CHECK_EN
    int sum_i;
    int exp_i;

    always_comb begin
        sum_i    = int'(a_full) + int'(b_full);
        exp_i    = expected_highs(dim, SPB);
        duty_bad = (sum_i > exp_i + DUTY_TOL) || (sum_i < exp_i - DUTY_TOL);
    end
`else
    logic unused_dim;

    assign unused_dim = ^dim;
    assign duty_bad   = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        samp_next     = sym_end ? '0 : samp_reg + 1'b1;
        a_next        = sym_end ? '0 : a_full;
        b_next        = sym_end ? '0 : b_full;
        low_next      = low_reg;
        bit_cnt_next  = bit_cnt_reg;
        shreg_next    = shreg_reg;
        rx_data_next  = rx_data_reg;
        rx_valid_next = 1'b0;
        sym_err_next  = 1'b0;

        case (state_reg)
            ST_HUNT: begin
                samp_next = '0;
                a_next    = '0;
                b_next    = '0;
                if (rs) begin
                    low_next = '0;
                    if (low_reg == RW'(SPB)) begin
                        // The edge sample is sample 0 of the start period (first half).
                        state_next = ST_START;
                        samp_next  = SW'(1);
                        a_next     = HW'(1);
                    end
                end else if (low_reg != RW'(SPB)) begin
                    low_next = low_reg + 1'b1;
                end
            end

            ST_START: begin
                if (sym_end) begin
                    if (!bit_val && !tie && !duty_bad) begin
                        state_next   = ST_DATA;
                        bit_cnt_next = '0;
                    end else begin
                        state_next = ST_HUNT;
                        low_next   = '0;
                    end
                end
            end

            ST_DATA: begin
                if (sym_end) begin
                    sym_err_next = tie || duty_bad;
                    if (bit_cnt_reg == BW'(WORD_W - 1)) begin
                        // Period counter keeps running so a back-to-back start symbol is caught.
                        rx_data_next  = {shreg_reg, bit_val};
                        rx_valid_next = 1'b1;
                        state_next    = ST_START;
                        bit_cnt_next  = '0;
                    end else begin
                        shreg_next   = {shreg_reg[WORD_W-3:0], bit_val};
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end

            default: begin
                state_next = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_HUNT;
            samp_reg     <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            low_reg      <= '0;
            bit_cnt_reg  <= '0;
            shreg_reg    <= '0;
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
            sym_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            samp_reg     <= samp_next;
            a_reg        <= a_next;
            b_reg        <= b_next;
            low_reg      <= low_next;
            bit_cnt_reg  <= bit_cnt_next;
            shreg_reg    <= shreg_next;
            rx_data_reg  <= rx_data_next;
            rx_valid_reg <= rx_valid_next;
            sym_err_reg  <= sym_err_next;
        end
    end

    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign sym_err  = sym_err_reg;
    assign rx_busy  = (state_reg != ST_HUNT);

endmodule

// File: tb/tb_vppm_rx_decoder.sv
// Bench for vppm_rx_decoder: a Tx-style VPPM encoder drives rx_in, expected words and
// error strobes are scheduled by absolute cycle, and a compare loop checks every cycle.
module tb_vppm_rx_decoder;

    localparam int SPB    = 16;
    localparam int WORD_W = 32;
    localparam int LAT    = 3;

    logic              pclk = 1'b0;
    logic              rst;
    logic              rx_in;
    logic [1:0]        dim;
    logic [WORD_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_busy;
    logic              sym_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [WORD_W-1:0] exp_word_at [int];
    bit                exp_err_at  [int];
    logic [WORD_W-1:0] held_word;

    vppm_rx_decoder #(.SPB(SPB), .WORD_W(WORD_W), .DUTY_TOL(1)) dut (
        .pclk     (pclk),
        .rst      (rst),
        .rx_in    (rx_in),
        .dim      (dim),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_busy  (rx_busy),
        .sym_err  (sym_err)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Tx model: number of high samples per symbol for a dimming code.
    function automatic int tx_highs(input logic [1:0] d);
        case (d)
            2'b01:   return SPB / 4;
            2'b10:   return (3 * SPB) / 4;
            2'b11:   return SPB / 8;
            default: return SPB / 2;
        endcase
    endfunction

    task automatic drive(input logic v);
        @(posedge pclk);
        #1 rx_in = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0);
    endtask

    // One VPPM symbol: bit 0 = pulse at period start, bit 1 = pulse at period end.
    task automatic send_sym(input logic b, input bit all_high, output int last_cyc);
        int h;
        h = tx_highs(dim);
        for (int s = 0; s < SPB; s++) begin
            if (all_high)  drive(1'b1);
            else if (b)    drive(s >= SPB - h);
            else           drive(s < h);
        end
        last_cyc = cyc;
    endtask

    task automatic send_start();
        int lc;
        send_sym(1'b0, 1'b0, lc);
    endtask

    // Data symbols MSB first; inj >= 0 replaces that symbol with an all-high period.
    task automatic send_word(input logic [WORD_W-1:0] word, input int inj);
        int lc;
        logic [WORD_W-1:0] expw;
        expw = word;
        for (int i = 0; i < WORD_W; i++) begin
            send_sym(word[WORD_W-1-i], i == inj, lc);
            if (i == inj) begin
                exp_err_at[lc + LAT] = 1'b1;
                expw[WORD_W-1-i] = 1'b0;
            end
        end
        exp_word_at[lc + LAT] = expw;
    endtask

    initial begin
        rst       = 1'b1;
        rx_in     = 1'b0;
        dim       = 2'b00;
        held_word = '0;

        fork
            forever begin
                @(negedge pclk);
                if (rst) begin
                    held_word = '0;
                end else begin
                    chk("rx_valid", {31'd0, rx_valid}, {31'd0, exp_word_at.exists(cyc)});
                    if (exp_word_at.exists(cyc)) begin
                        held_word = exp_word_at[cyc];
                        $display("word expected %h got %h at cycle %0d", held_word, rx_data, cyc);
                    end
                    chk("rx_data", rx_data, held_word);
                    chk("sym_err", {31'd0, sym_err}, {31'd0, exp_err_at.exists(cyc)});
                end
            end
        join_none

        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("reset rx_data", rx_data, 32'h0);
        chk("reset rx_valid", {31'd0, rx_valid}, 32'h0);
        chk("reset rx_busy", {31'd0, rx_busy}, 32'h0);
        chk("reset sym_err", {31'd0, sym_err}, 32'h0);
        @(posedge pclk);
        #1 rst = 1'b0;

        // Short low runs before rising edges must not leave HUNT.
        for (int i = 0; i < 8; i++) drive(1'b1);
        idle(10);
        for (int i = 0; i < 8; i++) drive(1'b1);
        chk("short run busy", {31'd0, rx_busy}, 32'h0);
        idle(4);
        @(negedge pclk);
        chk("short run busy late", {31'd0, rx_busy}, 32'h0);

        // Idle 20 periods, then a frame; busy must be up inside the frame.
        idle(20 * SPB);
        send_start();
        @(negedge pclk);
        chk("start busy", {31'd0, rx_busy}, 32'h1);
        send_word(32'hA5A5_F00F, -1);
        idle(8);
        @(negedge pclk);
        chk("frame1 literal", rx_data, 32'hA5A5_F00F);
        idle(2 * SPB);
        @(negedge pclk);
        chk("idle after frame busy", {31'd0, rx_busy}, 32'h0);

        // Back-to-back frames.
        idle(2 * SPB);
        send_start();
        send_word(32'h0000_0000, -1);
        send_start();
        send_word(32'hFFFF_FFFF, -1);
        send_start();
        send_word(32'h1234_5678, -1);
        idle(8);
        @(negedge pclk);
        chk("b2b last literal", rx_data, 32'h1234_5678);

        // Other dimming levels.
        for (int d = 1; d <= 2; d++) begin
            dim = 2'(d);
            idle(20 * SPB);
            send_start();
            send_word(32'hDEAD_BEEF, -1);
            idle(8);
        end
        dim = 2'b00;

        // Tied symbol at data bit index 5.
        idle(2 * SPB);
        send_start();
        send_word(32'h0F0F_0F0F, 5);
        idle(8);
        @(negedge pclk);
        chk("tie literal", rx_data, 32'h0B0F_0F0F);

        // Reset in the middle of a frame, then a clean frame.
        idle(2 * SPB);
        send_start();
        for (int i = 0; i < 17; i++) begin
            int lc;
            logic [31:0] w;
            w = 32'h1234_5678;
            send_sym(w[31-i], 1'b0, lc);
        end
        #2 rst = 1'b1;
        rx_in = 1'b0;
        @(negedge pclk);
        chk("midframe rst busy", {31'd0, rx_busy}, 32'h0);
        chk("midframe rst data", rx_data, 32'h0);
        chk("midframe rst valid", {31'd0, rx_valid}, 32'h0);
        repeat (2) @(posedge pclk);
        #1 rst = 1'b0;
        idle(3 * SPB);
        send_start();
        send_word(32'h5555_AAAA, -1);
        idle(8);
        @(negedge pclk);
        chk("post rst literal", rx_data, 32'h5555_AAAA);
        idle(4 * SPB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
